trap_ctrl: RTL

Sequences trap entry and trap return around csrfile. Watches the commit stage for ecall, mret and a level-sensitive machine timer interrupt. Drives the csrfile mepc/mcause/mstatus side-write ports, then issues a PC redirect to the IFU through a valid/ready handshake. While a trap or return is in flight it stalls the pipeline.

---
 rtl/trap_ctrl_pkg.sv | 23 ++
 rtl/trap_ctrl_stdreg.sv | 17 +
 rtl/trap_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap controller: mstatus fields, causes,
// mtvec modes and FSM state encodings.
package trap_ctrl_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_MTI   = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRAP  = 2'd1;
  localparam logic [1:0] ST_RET   = 2'd2;
  localparam logic [1:0] ST_REDIR = 2'd3;

endpackage

// File: rtl/trap_ctrl_stdreg.sv
// Plain resettable register with a parameterised reset value.
module trap_ctrl_stdreg #(
  parameter int           W         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_q <= RESET_VAL;
    else          o_q <= i_d;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry/return sequencer: CSR side-writes, then IFU redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          CPU_WIDTH_P = CPU_WIDTH,
  parameter logic [31:0] CAUSE_EC    = CAUSE_ECALL,
  parameter logic [31:0] CAUSE_TI    = CAUSE_MTI
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_commit_valid,
  input  logic [CPU_WIDTH_P-1:0] i_commit_pc,
  input  logic [CPU_WIDTH_P-1:0] i_commit_npc,
  input  logic                   i_commit_ecall,
  input  logic                   i_commit_mret,
  input  logic                   i_irq_mtip,
  input  logic                   i_irq_mtie,
  input  logic [CPU_WIDTH_P-1:0] i_mtvec,
  input  logic [CPU_WIDTH_P-1:0] i_mstatus,
  input  logic [CPU_WIDTH_P-1:0] i_mepc,
  output logic                   o_mepc_wen,
  output logic                   o_mcause_wen,
  output logic                   o_mstatus_wen,
  output logic [CPU_WIDTH_P-1:0] o_mepc_wdata,
  output logic [CPU_WIDTH_P-1:0] o_mcause_wdata,
  output logic [CPU_WIDTH_P-1:0] o_mstatus_wdata,
  output logic                   o_redirect_valid,
  output logic [CPU_WIDTH_P-1:0] o_redirect_pc,
  input  logic                   i_redirect_ready,
  output logic                   o_busy
);

  localparam int W = CPU_WIDTH_P;

  logic [1:0]   state_d, state_q;
  logic [W-1:0] epc_d, epc_q;
  logic [W-1:0] cause_d, cause_q;
  logic [W-1:0] tgt_d, tgt_q;
  logic [W-1:0] base;
  logic [W-1:0] ms;
  logic         irq_take;
  logic         unused_mepc_lsb;

  assign unused_mepc_lsb = ^i_mepc[1:0];
  assign base     = {i_mtvec[W-1:2], 2'b00};
  assign irq_take = i_irq_mtip & i_irq_mtie & i_mstatus[MSTATUS_MIE];

  trap_ctrl_stdreg #(
    .W         (2),
    .RESET_VAL (ST_IDLE)
  ) u_state (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (state_d),
    .o_q     (state_q)
  );

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    tgt_d            = tgt_q;
    ms               = i_mstatus;
    o_mepc_wen       = 1'b0;
    o_mcause_wen     = 1'b0;
    o_mstatus_wen    = 1'b0;
    o_mepc_wdata     = '0;
    o_mcause_wdata   = '0;
    o_mstatus_wdata  = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_commit_valid) begin
          if (i_commit_ecall) begin
            epc_d   = i_commit_pc;
            cause_d = CAUSE_EC;
            state_d = ST_TRAP;
          end else if (i_commit_mret) begin
            state_d = ST_RET;
          end else if (irq_take) begin
            epc_d   = i_commit_npc;
            cause_d = CAUSE_TI;
            state_d = ST_TRAP;
          end
        end
      end
      ST_TRAP: begin
        ms[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
        ms[MSTATUS_MIE]  = 1'b0;
        ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        o_mepc_wen      = 1'b1;
        o_mcause_wen    = 1'b1;
        o_mstatus_wen   = 1'b1;
        o_mepc_wdata    = epc_q;
        o_mcause_wdata  = cause_q;
        o_mstatus_wdata = ms;
        // Vectored mode offsets interrupts only; shifted-out bits wrap away
        if (i_mtvec[1:0] == MTVEC_VECTORED && cause_q[W-1])
          tgt_d = base + (cause_q << 2);
        else
          tgt_d = base;
        state_d = ST_REDIR;
      end
      ST_RET: begin
        ms[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
        ms[MSTATUS_MPIE] = 1'b1;
        ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        o_mstatus_wen   = 1'b1;
        o_mstatus_wdata = ms;
        tgt_d   = {i_mepc[W-1:2], 2'b00};
        state_d = ST_REDIR;
      end
      default: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = tgt_q;
        if (i_redirect_ready) state_d = ST_IDLE;
      end
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      epc_q   <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
